// File: rtl/mcpu_mem_arbiter.sv
// Round-robin arbiter sharing the MCPU RAM data port between fetch, load/store
// and the loader/debug port; one RAM pulse then a one-cycle ack per access.
module mcpu_mem_arbiter #(
    parameter int WORD_SIZE  = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int NREQ       = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           we,
    input  logic [NREQ-1:0]           lock,
    input  logic [NREQ*ADDR_WIDTH-1:0] addr,
    input  logic [NREQ*WORD_SIZE-1:0] wdata,
    output logic [NREQ-1:0]           ack,
    output logic [WORD_SIZE-1:0]      rdata,
    output logic [1:0]                owner,
    output logic                      busy,
    output logic                      ram_we,
    output logic                      ram_re,
    output logic [ADDR_WIDTH-1:0]     ram_addr,
    output logic [WORD_SIZE-1:0]      ram_wdata,
    input  logic [WORD_SIZE-1:0]      ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              owner_q, owner_d;
    logic                    locked_q, locked_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [WORD_SIZE-1:0]    wdata_q, wdata_d;
    logic [WORD_SIZE-1:0]    rdata_q, rdata_d;

    logic [ADDR_WIDTH-1:0]   addr_a  [NREQ];
    logic [WORD_SIZE-1:0]    wdata_a [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign addr_a[gi]  = addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_a[gi] = wdata[gi*WORD_SIZE +: WORD_SIZE];
    end

    // (base + k) mod 3 for base in 0..2 and k in 1..3.
    function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, k};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    logic [1:0] cand1, cand2, cand3;
    logic       grant;
    logic [1:0] winner;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        locked_d = locked_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        grant    = 1'b0;
        winner   = owner_q;
        cand1    = rr_idx(owner_q, 2'd1);
        cand2    = rr_idx(owner_q, 2'd2);
        cand3    = rr_idx(owner_q, 2'd3);

        case (state_q)
            S_IDLE: begin
                if (locked_q && req[owner_q]) begin
                    grant  = 1'b1;
                    winner = owner_q;
                end else begin
                    // A stale lock is released here so normal arbitration runs this cycle.
                    locked_d = 1'b0;
                    if (req[cand1]) begin
                        grant  = 1'b1;
                        winner = cand1;
                    end else if (req[cand2]) begin
                        grant  = 1'b1;
                        winner = cand2;
                    end else if (req[cand3]) begin
                        grant  = 1'b1;
                        winner = cand3;
                    end
                end
                if (grant) begin
                    we_d    = we[winner];
                    addr_d  = addr_a[winner];
                    wdata_d = wdata_a[winner];
                    owner_d = winner;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!we_q) rdata_d = ram_rdata;
                state_d = S_RESP;
            end
            S_RESP: begin
                locked_d = lock[owner_q];
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            owner_q  <= 2'd2;
            locked_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            locked_q <= locked_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    // RAM pins are decoded from state so an asynchronous reset kills a pulse at once.
    assign ram_we    = (state_q == S_GRANT) &&  we_q;
    assign ram_re    = (state_q == S_GRANT) && !we_q;
    assign ram_addr  = (state_q == S_GRANT) ? addr_q : '0;
    assign ram_wdata = ((state_q == S_GRANT) && we_q) ? wdata_q : '0;
    assign ack       = (state_q == S_RESP) ? (NREQ'(1) << owner_q) : '0;
    assign rdata     = rdata_q;
    assign owner     = owner_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mcpu_mem_arbiter.sv
// Scoreboard bench for mcpu_mem_arbiter: expected acks and read data are queued
// as stimulus is driven and popped when the arbiter acknowledges.
module tb_mcpu_mem_arbiter;

    localparam int W  = 16;
    localparam int AW = 8;
    localparam int EW = 20;  // {ack[2:0], is_read, rdata[15:0]}

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    req, we, lock;
    logic [3*AW-1:0] addr;
    logic [3*W-1:0]  wdata;
    logic [2:0]    ack;
    logic [W-1:0]  rdata;
    logic [1:0]    owner;
    logic          busy;
    logic          ram_we, ram_re;
    logic [AW-1:0] ram_addr;
    logic [W-1:0]  ram_wdata;
    logic [W-1:0]  ram_rdata;

    logic [W-1:0]  mem [256];
    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [W-1:0]  pre_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [EW-1:0] exp_q[$];

    mcpu_mem_arbiter #(.WORD_SIZE(W), .ADDR_WIDTH(AW), .NREQ(3)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .lock(lock),
        .addr(addr), .wdata(wdata), .ack(ack), .rdata(rdata), .owner(owner),
        .busy(busy), .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // RAM model: combinational read, write on the rising edge.
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        else if (pre_en) mem[pre_addr] <= pre_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input int idx, input logic is_read, input logic [W-1:0] d);
        logic [2:0] a;
        a = 3'b000;
        a[idx] = 1'b1;
        exp_q.push_back({a, is_read, d});
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic set_req(input int idx, input logic w, input logic [AW-1:0] a, input logic [W-1:0] d);
        we[idx] = w;
        addr[idx*AW +: AW] = a;
        wdata[idx*W +: W] = d;
        req[idx] = 1'b1;
    endtask

    // One access from an idle arbiter; checks the RAM pulse and the 2-cycle latency.
    task automatic single(input int idx, input logic w, input logic [AW-1:0] a,
                          input logic [W-1:0] d, input logic lk, input logic [W-1:0] exp_rd);
        int lat;
        logic got;
        @(negedge clk);
        push_exp(idx, !w, exp_rd);
        set_req(idx, w, a, d);
        lock[idx] = lk;
        got = 1'b0;
        lat = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            lat++;
            if (ram_we || ram_re) begin
                check("ram_addr", 32'(ram_addr), 32'(a));
                check("ram_we", 32'(ram_we), 32'(w));
                if (w) check("ram_wdata", 32'(ram_wdata), 32'(d));
            end
            if (ack[idx]) got = 1'b1;
        end
        check("ack_seen", 32'(got), 1);
        check("latency", lat, 2);
        req[idx] = 1'b0;
    endtask

    // Waits for n acks; clears all locks at ack number unlock_at, drops all reqs at the last.
    task automatic stream(input int n, input int unlock_at, input logic chk_gap);
        int seen;
        int last;
        seen = 0;
        last = 0;
        for (int c = 0; c < 20 * n && seen < n; c++) begin
            @(negedge clk);
            if (ack != 3'b000) begin
                seen++;
                if (chk_gap && seen > 1) check("ack_gap", cyc - last, 3);
                last = cyc;
                if (seen == unlock_at) lock = 3'b000;
                if (seen == n) req = 3'b000;
            end
        end
        check("stream_acks", seen, n);
        req = 3'b000;
    endtask

    // Monitor: invariants every cycle, scoreboard pop on every ack.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (reset === 1'b1) begin
            check("rw_excl", 32'(ram_we & ram_re), 0);
            check("ack_onehot", 32'(ack & (ack - 3'd1)), 0);
            if (ack != 3'b000) begin
                if (exp_q.size() == 0) begin
                    check("ack_unexpected", 32'(ack), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_owner", 32'(ack), 32'(e[19:17]));
                    if (e[16]) check("rdata", 32'(rdata), 32'(e[15:0]));
                end
            end
        end
    end

    initial begin
        reset = 1'b0; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;

        preload(8'h12, 16'hBEEF);
        preload(8'h01, 16'h1111);
        preload(8'h02, 16'h2222);
        preload(8'h03, 16'h3333);
        preload(8'h40, 16'h0000);

        // Reset values
        check("rst_ack", 32'(ack), 0);
        check("rst_rdata", 32'(rdata), 0);
        check("rst_owner", 32'(owner), 2);
        check("rst_busy", 32'(busy), 0);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_ram_re", 32'(ram_re), 0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_ram_wdata", 32'(ram_wdata), 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_busy", 32'(busy), 0);
            check("idle_ram", 32'({ram_we, ram_re}), 0);
            check("idle_ack", 32'(ack), 0);
            check("idle_owner", 32'(owner), 2);
        end

        // Single read by load/store port
        single(1, 1'b0, 8'h12, 16'h0, 1'b0, 16'hBEEF);
        check("owner_after_read", 32'(owner), 1);

        // Write then readback by loader
        single(2, 1'b1, 8'h40, 16'h00A5, 1'b0, 16'h0);
        check("mem_written", 32'(mem[8'h40]), 32'h00A5);
        single(2, 1'b0, 8'h40, 16'h0, 1'b0, 16'h00A5);

        // Contention from reset: round robin 0,1,2,0,1,2
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        set_req(0, 1'b0, 8'h01, 16'h0);
        set_req(1, 1'b0, 8'h02, 16'h0);
        set_req(2, 1'b0, 8'h03, 16'h0);
        for (int r = 0; r < 2; r++) begin
            push_exp(0, 1'b1, 16'h1111);
            push_exp(1, 1'b1, 16'h2222);
            push_exp(2, 1'b1, 16'h3333);
        end
        reset = 1'b1;
        stream(6, 0, 1'b1);
        check("owner_after_rr", 32'(owner), 2);

        // Lock: loader takes the port with lock, keeps it while requester 0 waits
        single(2, 1'b0, 8'h03, 16'h0, 1'b1, 16'h3333);
        set_req(0, 1'b0, 8'h01, 16'h0);
        set_req(2, 1'b0, 8'h03, 16'h0);
        push_exp(2, 1'b1, 16'h3333);
        push_exp(2, 1'b1, 16'h3333);
        push_exp(0, 1'b1, 16'h1111);
        stream(3, 2, 1'b1);

        // Reset in the middle of an access
        @(negedge clk);
        @(negedge clk);
        set_req(1, 1'b0, 8'h12, 16'h0);
        @(negedge clk);
        check("mid_pulse", 32'(ram_re), 1);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_ram", 32'({ram_we, ram_re}), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ack", 32'(ack), 0);
        check("mid_rst_owner", 32'(owner), 2);
        @(negedge clk);
        set_req(0, 1'b0, 8'h01, 16'h0);
        push_exp(0, 1'b1, 16'h1111);
        push_exp(1, 1'b1, 16'hBEEF);
        reset = 1'b1;
        stream(2, 0, 1'b1);

        repeat (4) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mcpu_mem_arbiter.md
Name: mcpu_mem_arbiter

Overview:
- Round-robin arbiter sharing the single data port of the MCPU RAM controller between three requesters: 0 = CPU instruction fetch, 1 = CPU load/store, 2 = external program loader/debug port.
- Each access is serialized as one RAM read or write pulse, followed by a one-cycle acknowledge to the owning requester.
- A lock input lets the current owner keep the port for back-to-back accesses, for example loader bursts.
- The block sits between the CPU/loader masters and the RAM controller's we/re/addr/datawr/datard pins.

Parameters:
- WORD_SIZE, 16, data width in bits.
- ADDR_WIDTH, 8, RAM address width.
- NREQ, 3, number of requesters. Fixed at 3; other values are not supported.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  3  request per requester; bit i belongs to requester i.
- we  input  3  per requester: 1 = write, 0 = read. Sampled at grant.
- lock  input  3  per requester: hold ownership after the current access.
- addr  input  3*ADDR_WIDTH  requester i address at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- wdata  input  3*WORD_SIZE  requester i write data at bits [i*WORD_SIZE +: WORD_SIZE].
- ack  output  3  one-cycle completion pulse to the owning requester.
- rdata  output  WORD_SIZE  read data; valid only in the cycle ack is high and the access was a read.
- owner  output  2  index of the current/last granted requester.
- busy  output  1  high in the GRANT and RESP states.
- ram_we  output  1  RAM write enable.
- ram_re  output  1  RAM read enable.
- ram_addr  output  ADDR_WIDTH  RAM address.
- ram_wdata  output  WORD_SIZE  RAM write data.
- ram_rdata  input  WORD_SIZE  RAM read data; valid in the same cycle ram_re is high.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; ack=0, rdata=0, owner=2, busy=0; ram_we=0, ram_re=0, ram_addr=0, ram_wdata=0; locked=0.
  - Owner is 2 so that requester 0 has first priority after reset.
  - Takes effect immediately, including mid-access. A pending pulse is dropped; no ack is issued for it.
- State IDLE:
  - If locked=1 and req[owner]=1: grant owner again.
  - Else if any req bit is set: grant the first set bit scanning owner+1, owner+2, owner+3 (mod 3).
  - On grant: latch we/addr/wdata of the winner; owner<=winner; next state GRANT.
  - If locked=1 but req[owner]=0: clear locked and arbitrate normally in the same cycle.
  - No req set: stay in IDLE; all outputs idle.
- State GRANT (exactly 1 cycle): ram_addr/ram_wdata driven from the latched values; ram_we=latched we; ram_re=~latched we; capture ram_rdata into rdata on reads; next state RESP.
- State RESP (exactly 1 cycle):
  - ram_we=0, ram_re=0.
  - ack[owner]=1; all other ack bits 0.
  - locked <= lock[owner].
  - Next state IDLE.
- Latency: request seen in IDLE at cycle N -> RAM pulse at N+1 -> ack at N+2. Maximum throughput is one access every 3 cycles.
- Request rules:
  - Requesters hold req, we, addr and wdata stable until ack.
  - A req dropped after grant does not cancel the access; ack is still issued.
  - A req held high after ack is treated as a new request at the next IDLE.
- rdata holds its last value otherwise. For writes it is unchanged and must not be used.
- Never more than one ack bit high. ram_we and ram_re are never both high and never high outside GRANT.
- Fairness: without lock, a continuously requesting master waits at most 2 other accesses (6 cycles) before its grant.
- ADDR_WIDTH wrap: addresses pass through unmodified; there is no address arithmetic.
- RAM pulse timing: matches the controller's single-cycle we/re timing, so no wait states are needed.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, then 1 with req=0 -> all outputs at reset values, busy=0 for 10 cycles.
- Single read: RAM[0x12]=0xBEEF; req=3'b010, we=0, addr1=0x12 -> ram_re=1 with ram_addr=0x12 at cycle+1; ack=3'b010 and rdata=0xBEEF at cycle+2.
- Write then readback: requester 2 writes 0x00A5 to 0x40, then reads 0x40 -> ram_we pulse with ram_wdata=0x00A5; second ack returns rdata=0x00A5.
- Contention: req=3'b111 held continuously from reset -> grant order 0,1,2,0,1,2; acks exactly 3 cycles apart.
- Lock: req=3'b101, lock[2]=1, owner=2 -> requester 2 receives consecutive grants; after lock[2] drops, the next grant goes to 0.
- Reset mid-access: assert reset during GRANT -> ram_we/ram_re fall to 0 immediately; no ack; first grant after release goes to requester 0.
